// File: rtl/pila_retorno_pkg.sv
// Shared definitions for the return-address stack and the IP datapath it feeds.
`default_nettype none

package pila_retorno_pkg;

  localparam int ADDR_W        = 16;
  localparam int DEFAULT_DEPTH = 8;

  // Request opcode, formed as {CALL, RET}
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RET  = 2'b01,
    OP_CALL = 2'b10,
    OP_TAIL = 2'b11
  } op_e;

endpackage

`default_nettype wire

// File: rtl/pila_retorno_mem.sv
// Return-address storage: one synchronous write port, one asynchronous read port.
`default_nettype none

module pila_retorno_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/pila_retorno.sv
// Return-address stack driving the IP register load path (CALL/RET/tail-call).
`default_nettype none

module pila_retorno
  import pila_retorno_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             call_i,
  input  logic             ret_i,
  input  logic [WIDTH-1:0] ip_in_i,
  input  logic [WIDTH-1:0] call_addr_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] target_o,
  output logic             redirect_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             redirect_q, redirect_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             we;
  logic [PTR_W-1:0] waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic [PTR_W-1:0] top_idx;
  logic             full, empty;
  logic             set_ovf, set_unf;
  op_e              op;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // Low bits wrap correctly when COUNT==DEPTH: top entry is DEPTH-1.
  assign top_idx = count_q[PTR_W-1:0] - PTR_W'(1);

  pila_retorno_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (top_idx),
    .rdata_o (rdata)
  );

  always_comb begin
    op         = op_e'({call_i, ret_i});
    count_d    = count_q;
    target_d   = target_q;
    redirect_d = 1'b0;
    we         = 1'b0;
    waddr      = count_q[PTR_W-1:0];
    wdata      = ip_in_i + WIDTH'(1);
    set_ovf    = 1'b0;
    set_unf    = 1'b0;

    case (op)
      OP_CALL: begin
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          we         = 1'b1;
          count_d    = count_q + (PTR_W+1)'(1);
          target_d   = call_addr_i;
          redirect_d = 1'b1;
        end
      end
      OP_RET: begin
        if (empty) begin
          set_unf = 1'b1;
        end else begin
          count_d    = count_q - (PTR_W+1)'(1);
          target_d   = rdata;
          redirect_d = 1'b1;
        end
      end
      // Tail call replaces the top entry; on an empty stack it is a plain push.
      OP_TAIL: begin
        we         = 1'b1;
        target_d   = call_addr_i;
        redirect_d = 1'b1;
        if (empty) begin
          count_d = count_q + (PTR_W+1)'(1);
        end else begin
          waddr = top_idx;
        end
      end
      default: ;
    endcase

    ovf_d = set_ovf | (ovf_q & ~clr_err_i);
    unf_d = set_unf | (unf_q & ~clr_err_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= '0;
      target_q   <= '0;
      redirect_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      target_q   <= target_d;
      redirect_q <= redirect_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign target_o   = target_q;
  assign redirect_o = redirect_q;
  assign count_o    = count_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign ovf_o      = ovf_q;
  assign unf_o      = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_pila_retorno.sv
// Self-checking bench for pila_retorno: vector table fed through a scoreboard queue.
`default_nettype none

module tb_pila_retorno;

  logic        clk;
  logic        rst;
  logic        call;
  logic        ret;
  logic [15:0] ip_in;
  logic [15:0] call_addr;
  logic        clr_err;
  logic [15:0] target;
  logic        redirect;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        ovf;
  logic        unf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        call;
    logic        ret;
    logic        clr;
    logic [15:0] ip;
    logic [15:0] addr;
    logic        redir;
    logic [15:0] tgt;
    logic [3:0]  cnt;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  pila_retorno dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .call_i      (call),
    .ret_i       (ret),
    .ip_in_i     (ip_in),
    .call_addr_i (call_addr),
    .clr_err_i   (clr_err),
    .target_o    (target),
    .redirect_o  (redirect),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .ovf_o       (ovf),
    .unf_o       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic c, input logic r, input logic cl,
                              input logic [15:0] ip, input logic [15:0] ad,
                              input logic rd, input logic [15:0] tg,
                              input logic [3:0] cn, input logic ov, input logic un);
    vec_t v;
    v.call = c; v.ret = r; v.clr = cl; v.ip = ip; v.addr = ad;
    v.redir = rd; v.tgt = tg; v.cnt = cn; v.ovf = ov; v.unf = un;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input vec_t e);
    chk("redirect", idx, 16'(redirect), 16'(e.redir));
    chk("target",   idx, target, e.tgt);
    chk("count",    idx, 16'(count), 16'(e.cnt));
    chk("full",     idx, 16'(full), 16'(e.cnt == 4'd8));
    chk("empty",    idx, 16'(empty), 16'(e.cnt == 4'd0));
    chk("ovf",      idx, 16'(ovf), 16'(e.ovf));
    chk("unf",      idx, 16'(unf), 16'(e.unf));
  endtask

  // Drive one request, queue its expectation, compare after the edge.
  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    call = v.call; ret = v.ret; clr_err = v.clr; ip_in = v.ip; call_addr = v.addr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: empty at step %0d", idx);
    end else begin
      e = sb.pop_front();
      check_outputs(idx, e);
    end
    call = 1'b0; ret = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; call = 1'b0; ret = 1'b0; clr_err = 1'b0;
    ip_in = '0; call_addr = '0;

    // Idle after reset
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,0,16'h0,16'h0, 0,16'h0000,0,0,0));
    // Single call / return
    vecs.push_back(mk(1,0,0,16'h0100,16'h2000, 1,16'h2000,1,0,0));
    vecs.push_back(mk(0,1,0,16'h0000,16'h0000, 1,16'h0101,0,0,0));
    // Fill to DEPTH
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1,0,0,16'h0010 + 16'(i),16'h1000 + 16'(i), 1,16'h1000 + 16'(i),4'(i+1),0,0));
    // Overflow: no redirect, target holds
    vecs.push_back(mk(1,0,0,16'h0050,16'h5000, 0,16'h1007,8,1,0));
    // Drain in LIFO order
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0,1,0,16'h0,16'h0, 1,16'h0018 - 16'(k),4'(7-k),1,0));
    // Underflow, clear, clear racing a new underflow, clear
    vecs.push_back(mk(0,1,0,16'h0,16'h0, 0,16'h0011,0,1,1));
    vecs.push_back(mk(0,0,1,16'h0,16'h0, 0,16'h0011,0,0,0));
    vecs.push_back(mk(0,1,1,16'h0,16'h0, 0,16'h0011,0,0,1));
    vecs.push_back(mk(0,0,1,16'h0,16'h0, 0,16'h0011,0,0,0));
    // Wrap push, tail call overwriting it, return
    vecs.push_back(mk(1,0,0,16'hFFFF,16'hAAAA, 1,16'hAAAA,1,0,0));
    vecs.push_back(mk(1,1,0,16'h3000,16'h4000, 1,16'h4000,1,0,0));
    vecs.push_back(mk(0,1,0,16'h0,16'h0, 1,16'h3001,0,0,0));
    // Wrap value observed directly
    vecs.push_back(mk(1,0,0,16'hFFFF,16'hBBBB, 1,16'hBBBB,1,0,0));
    vecs.push_back(mk(0,1,0,16'h0,16'h0, 1,16'h0000,0,0,0));
    // Tail call on empty stack acts as plain call, no underflow
    vecs.push_back(mk(1,1,0,16'h0200,16'h6000, 1,16'h6000,1,0,0));
    vecs.push_back(mk(0,1,0,16'h0,16'h0, 1,16'h0201,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0,16'h0, 0,16'h0201,0,0,0));

    // Reset values while held
    #12;
    check_outputs(-1, mk(0,0,0,16'h0,16'h0, 0,16'h0000,0,0,0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Asynchronous reset between edges after three pushes
    run_vec(100, mk(1,0,0,16'h0700,16'h7000, 1,16'h7000,1,0,0));
    run_vec(101, mk(1,0,0,16'h0701,16'h7001, 1,16'h7001,2,0,0));
    run_vec(102, mk(1,0,0,16'h0702,16'h7002, 1,16'h7002,3,0,0));
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_outputs(103, mk(0,0,0,16'h0,16'h0, 0,16'h0000,0,0,0));
    #1 rst = 1'b0;
    run_vec(104, mk(0,1,0,16'h0,16'h0, 0,16'h0000,0,0,1));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left over", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pila_retorno.md
Name: pila_retorno

Overview:
- Return-address stack that drives the load path of the 16-bit instruction-pointer register.
- On a CALL it saves the address after the current instruction and redirects the IP to the call target.
- On a RET it pops the saved address and redirects the IP back to it.
- Outputs REDIRECT/TARGET connect directly to the IP register's SEL/D inputs, with REDIRECT also OR-ed into its ENA.

Parameters:
- WIDTH, 16, address width; must match the IP register.
- DEPTH, 8, number of stack entries; power of two, minimum 2.
- PTR_W, 3, log2(DEPTH); derived, never overridden.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- CALL  input  1  call request, sampled on rising CLK.
- RET  input  1  return request, sampled on rising CLK.
- IP_IN  input  WIDTH  current IP value, the address of the call instruction.
- CALL_ADDR  input  WIDTH  call destination.
- CLR_ERR  input  1  clears the sticky OVF/UNF flags.
- TARGET  output  WIDTH  redirect address; drives IP register D.
- REDIRECT  output  1  one-cycle pulse; drives IP register SEL=1 and ENA.
- COUNT  output  PTR_W+1  number of valid entries, 0..DEPTH.
- FULL  output  1  COUNT==DEPTH.
- EMPTY  output  1  COUNT==0.
- OVF  output  1  sticky overflow flag.
- UNF  output  1  sticky underflow flag.

Behaviour:
- Reset (async, any time, including mid-operation):
  - COUNT=0, TARGET=0, REDIRECT=0, OVF=0, UNF=0, EMPTY=1, FULL=0.
  - Stack array contents are don't-care.
- TARGET and REDIRECT are registered, so there is 1-cycle latency from the sampled request to the REDIRECT pulse.
- When no request is accepted: REDIRECT=0 next cycle and TARGET holds its last value.
- Return address = IP_IN+1, computed modulo 2^WIDTH (IP_IN=FFFF gives 0000). No carry-out.
- CALL only, not FULL:
  - mem[COUNT] <= IP_IN+1; COUNT++.
  - TARGET <= CALL_ADDR; REDIRECT <= 1.
- CALL only, FULL:
  - No push, no redirect; COUNT unchanged.
  - OVF <= 1. The IP keeps incrementing; software detects the error through OVF.
- RET only, not EMPTY:
  - TARGET <= mem[COUNT-1]; COUNT--; REDIRECT <= 1.
- RET only, EMPTY:
  - No redirect; UNF <= 1; COUNT stays 0 (no wrap below zero).
- CALL and RET in the same cycle (tail call):
  - Not EMPTY: the top entry is overwritten with IP_IN+1; COUNT unchanged; TARGET <= CALL_ADDR; REDIRECT <= 1.
  - EMPTY: behaves exactly as CALL only. UNF is not set.
- CLR_ERR clears OVF/UNF at the next edge. If an error is raised in the same cycle, setting the flag wins.
- FULL and EMPTY are combinational decodes of COUNT.
- Back-to-back requests are legal on every cycle. Each request uses the COUNT value from the previous edge; there is no bubble.
- The caller must not rely on IP_IN during the cycle in which REDIRECT=1, because the IP register is loading.

Decomposition:
- Shared package holds:
  - ADDR_W=16 (shared with the IP register).
  - Opcode encoding constants OP_NONE/OP_CALL/OP_RET/OP_TAIL, decoded from {CALL,RET}.
  - Default DEPTH.
- One natural sub-module: pila_mem, a DEPTH x WIDTH register file with one synchronous write port and one asynchronous read port at address COUNT-1.
- The top level holds the COUNT pointer, the output registers, and the flag logic.

Test Plan:
- Reset then idle: RST=1 → all outputs at reset values. Release RST, idle 5 cycles → REDIRECT stays 0, EMPTY=1.
- Single call/return:
  - CALL with IP_IN=0x0100, CALL_ADDR=0x2000 → next cycle TARGET=0x2000, REDIRECT=1, COUNT=1.
  - RET → next cycle TARGET=0x0101, REDIRECT=1, COUNT=0.
- Nesting and overflow (DEPTH=8):
  - 8 CALLs with IP_IN=0x10..0x17 → FULL=1.
  - 9th CALL → REDIRECT=0, OVF=1, COUNT=8.
  - 8 RETs → TARGETs 0x18,0x17,...,0x11 in that order.
- Underflow and flag clear: RET when EMPTY → REDIRECT=0, UNF=1, COUNT=0. CLR_ERR=1 → UNF=0 next cycle. CLR_ERR together with a new underflow → UNF stays 1.
- Wrap and tail call:
  - CALL with IP_IN=0xFFFF → pushed value 0x0000.
  - Then CALL+RET with IP_IN=0x3000, CALL_ADDR=0x4000 → TARGET=0x4000, COUNT=1.
  - RET → TARGET=0x3001.
- Async reset mid-burst: assert RST between clock edges after 3 pushes → COUNT=0 and REDIRECT=0 immediately, without waiting for an edge. Subsequent RET → UNF=1.
